// File: rtl/fifo_level_pkg.sv
// ============================================================================
// fifo_level_pkg : shared FIFO sizing helper and parameter legality check
// Revision 1.0
// ============================================================================
`default_nettype none

package fifo_level_pkg;

    // Level and pointer width: one extra bit so a full FIFO is distinguishable from empty.
    function automatic int level_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

    function automatic bit params_legal(
        input int data_bits,
        input int depth_bits,
        input int afull_level,
        input int aempty_level
    );
        int depth;
        depth = 1 << depth_bits;
        return (data_bits >= 1)
            && (depth_bits >= 1) && (depth_bits <= 12)
            && (afull_level >= 1) && (afull_level <= depth)
            && (aempty_level >= 0) && (aempty_level <= depth - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_level_mem.sv
// ============================================================================
// fifo_mem : simple dual-port register array, synchronous write, async read
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_mem #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0]  i_wdata,
    input  logic [DEPTH_BITS-1:0] i_raddr,
    output logic [DATA_BITS-1:0]  o_rdata
);

    logic [DATA_BITS-1:0] r_mem [0:(1<<DEPTH_BITS)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_level.sv
// ============================================================================
// fifo_level : FWFT synchronous FIFO with fill level, thresholds, flush and
//              sticky overflow/underflow flags
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH_BITS   = 2,
    parameter int AFULL_LEVEL  = 3,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  write_i,
    input  logic [DATA_BITS-1:0]  write_data_i,
    output logic                  write_ready_o,
    input  logic                  read_i,
    output logic [DATA_BITS-1:0]  read_data_o,
    output logic                  read_ready_o,
    output logic [DEPTH_BITS:0]   level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int LW = level_width(DEPTH_BITS);
    localparam logic [LW-1:0] c_afull  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] c_aempty = LW'(AEMPTY_LEVEL);

    generate
        if (!params_legal(DATA_BITS, DEPTH_BITS, AFULL_LEVEL, AEMPTY_LEVEL)) begin : g_param_err
            $error("fifo_level: parameter out of legal range");
        end
    endgenerate

    logic [LW-1:0] r_waddr;
    logic [LW-1:0] r_raddr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_underflow;

    logic w_empty;
    logic w_full;
    logic w_do_write;
    logic w_do_read;

    assign w_empty = (r_waddr == r_raddr);
    assign w_full  = (r_waddr[DEPTH_BITS] != r_raddr[DEPTH_BITS])
                  && (r_waddr[DEPTH_BITS-1:0] == r_raddr[DEPTH_BITS-1:0]);

    // Only the full flag gates a write; a same-cycle read never frees a slot early.
    assign w_do_write = write_i & ~w_full;
    assign w_do_read  = read_i & ~w_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_write) r_waddr <= r_waddr + LW'(1);
            if (w_do_read)  r_raddr <= r_raddr + LW'(1);
            case ({w_do_write, w_do_read})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (write_i && w_full) r_overflow  <= 1'b1;
            if (read_i && w_empty) r_underflow <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_mem (
        .clk     (clock),
        .i_we    (w_do_write & ~flush_i),
        .i_waddr (r_waddr[DEPTH_BITS-1:0]),
        .i_wdata (write_data_i),
        .i_raddr (r_raddr[DEPTH_BITS-1:0]),
        .o_rdata (read_data_o)
    );

    assign write_ready_o  = ~w_full;
    assign read_ready_o   = ~w_empty;
    assign level_o        = r_level;
    assign almost_full_o  = (r_level >= c_afull);
    assign almost_empty_o = (r_level <= c_aempty);
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_level.sv
// ============================================================================
// tb_fifo_level : directed self-checking bench for fifo_level (8-bit, depth 4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fifo_level;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush_i = 1'b0;
    logic       write_i = 1'b0;
    logic [7:0] write_data_i = 8'h00;
    logic       write_ready_o;
    logic       read_i = 1'b0;
    logic [7:0] read_data_o;
    logic       read_ready_o;
    logic [2:0] level_o;
    logic       almost_full_o;
    logic       almost_empty_o;
    logic       overflow_o;
    logic       underflow_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    fifo_level #(
        .DATA_BITS    (8),
        .DEPTH_BITS   (2),
        .AFULL_LEVEL  (3),
        .AEMPTY_LEVEL (1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .flush_i        (flush_i),
        .write_i        (write_i),
        .write_data_i   (write_data_i),
        .write_ready_o  (write_ready_o),
        .read_i         (read_i),
        .read_data_o    (read_data_o),
        .read_ready_o   (read_ready_o),
        .level_o        (level_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level_o); end
        checks++; if ({write_ready_o, read_ready_o, almost_full_o, almost_empty_o} !== 4'b1001) begin
            errors++; $display("FAIL reset_flags got wr/rr/af/ae=%b want 1001", {write_ready_o, read_ready_o, almost_full_o, almost_empty_o}); end
        checks++; if ({overflow_o, underflow_o} !== 2'b00) begin
            errors++; $display("FAIL reset_err got %b want 00", {overflow_o, underflow_o}); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            write_i = 1'b1;
            write_data_i = vals[i];
            tick();
            q.push_back(vals[i]);
            checks++; if (level_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level_o, i + 1); end
            checks++; if (almost_empty_o !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_aempty[%0d] got %b want %b", i, almost_empty_o, (i + 1 <= 1)); end
            checks++; if (almost_full_o !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full_o, (i + 1 >= 3)); end
            checks++; if (write_ready_o !== (i + 1 < 4)) begin errors++; $display("FAIL fill_wready[%0d] got %b want %b", i, write_ready_o, (i + 1 < 4)); end
            checks++; if (read_data_o !== 8'h11) begin errors++; $display("FAIL fill_head[%0d] got %h want 11", i, read_data_o); end
        end
        write_i = 1'b0;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            read_i = 1'b1;
            checks++; if (read_data_o !== q[0]) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, read_data_o, q[0]); end
            void'(q.pop_front());
            tick();
            checks++; if (level_o !== 3'(3 - i)) begin errors++; $display("FAIL drain_level[%0d] got %0d want %0d", i, level_o, 3 - i); end
        end
        read_i = 1'b0;
        checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL drain_rready got %b want 0", read_ready_o); end
        checks++; if ({overflow_o, underflow_o} !== 2'b00) begin errors++; $display("FAIL drain_err got %b want 00", {overflow_o, underflow_o}); end
    endtask

    task automatic test_wrap();
        write_i = 1'b1;
        write_data_i = 8'hA0; tick(); q.push_back(8'hA0);
        write_data_i = 8'hA1; tick(); q.push_back(8'hA1);
        read_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            write_data_i = 8'(i);
            checks++; if (read_data_o !== q[0]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, read_data_o, q[0]); end
            void'(q.pop_front());
            q.push_back(8'(i));
            tick();
            checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL wrap_level[%0d] got %0d want 2", i, level_o); end
        end
        write_i = 1'b0;
        read_i = 1'b0;
    endtask

    task automatic test_errors();
        write_i = 1'b1;
        write_data_i = 8'hB0; tick(); q.push_back(8'hB0);
        write_data_i = 8'hB1; tick(); q.push_back(8'hB1);
        write_data_i = 8'h55; tick();
        write_i = 1'b0;
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_o); end
        checks++; if (level_o !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", level_o); end
        for (int i = 0; i < 4; i++) begin
            read_i = 1'b1;
            checks++; if (read_data_o !== q[0]) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, read_data_o, q[0]); end
            void'(q.pop_front());
            tick();
        end
        checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL unf_early got %b want 0", underflow_o); end
        tick();
        read_i = 1'b0;
        checks++; if ({overflow_o, underflow_o} !== 2'b11) begin errors++; $display("FAIL unf_set got %b want 11", {overflow_o, underflow_o}); end
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL unf_level got %0d want 0", level_o); end
        tick();
        checks++; if ({overflow_o, underflow_o} !== 2'b11) begin errors++; $display("FAIL err_sticky got %b want 11", {overflow_o, underflow_o}); end
    endtask

    task automatic test_flush();
        write_i = 1'b1;
        write_data_i = 8'hC0; tick();
        write_data_i = 8'hC1; tick();
        write_data_i = 8'hC2; tick();
        checks++; if (level_o !== 3'd3) begin errors++; $display("FAIL preflush_level got %0d want 3", level_o); end
        flush_i = 1'b1;
        read_i = 1'b1;
        write_data_i = 8'hEE;
        tick();
        flush_i = 1'b0;
        read_i = 1'b0;
        write_i = 1'b0;
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL flush_level got %0d want 0", level_o); end
        checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL flush_rready got %b want 0", read_ready_o); end
        checks++; if ({overflow_o, underflow_o} !== 2'b00) begin errors++; $display("FAIL flush_err got %b want 00", {overflow_o, underflow_o}); end
        tick();
        checks++; if ({level_o, read_ready_o} !== 4'b0000) begin errors++; $display("FAIL flush_absent got level/rr=%b want 0000", {level_o, read_ready_o}); end
        write_i = 1'b1;
        write_data_i = 8'h77;
        tick();
        write_i = 1'b0;
        q.push_back(8'h77);
        checks++; if (read_data_o !== 8'h77) begin errors++; $display("FAIL postflush_data got %h want 77", read_data_o); end
    endtask

    task automatic test_async_reset();
        write_i = 1'b1;
        write_data_i = 8'h88;
        tick();
        write_i = 1'b0;
        checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL prereset_level got %0d want 2", level_o); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL areset_level got %0d want 0", level_o); end
        checks++; if ({write_ready_o, read_ready_o, almost_full_o, almost_empty_o} !== 4'b1001) begin
            errors++; $display("FAIL areset_flags got wr/rr/af/ae=%b want 1001", {write_ready_o, read_ready_o, almost_full_o, almost_empty_o}); end
        #2;
        reset_n = 1'b1;
        tick();
        write_i = 1'b1;
        write_data_i = 8'h99;
        tick();
        write_i = 1'b0;
        checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL resume_level got %0d want 1", level_o); end
        checks++; if (read_data_o !== 8'h99) begin errors++; $display("FAIL resume_data got %h want 99", read_data_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_errors();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
